// File: rtl/timer_pkg.sv
// Shared constants and types for the two-digit BCD timer.
// Digit width and the largest legal BCD digit value live here.
package timer_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t DIGIT_MAX = bcd_t'(9);

  function automatic bcd_t tens_of(input int v);
    return bcd_t'(v / 10);
  endfunction

  function automatic bcd_t ones_of(input int v);
    return bcd_t'(v % 10);
  endfunction

endpackage

// File: rtl/timer_bcd_digit.sv
// One registered BCD digit with increment, clear and terminal value.
// carry is high while the digit sits on its terminal value.
module bcd_digit
  import timer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  input  bcd_t term,
  output bcd_t digit,
  output logic carry
);

  bcd_t digit_d;
  bcd_t digit_q;

  // >= keeps the digit in range even if term is ever lowered
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      if (digit_q >= term) begin
        digit_d = '0;
      end else begin
        digit_d = digit_q + bcd_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = (digit_q == term);

endmodule

// File: rtl/timer.sv
// Two-digit BCD up-counter wrapping from MAX_COUNT to 00.
// Digits are chained through the ones carry; wrap clears both.
module timer
  import timer_pkg::*;
#(
  parameter int MAX_COUNT = 59
) (
  input  logic               clk_1hz,
  input  logic               rst_n,
  input  logic               en,
  output logic [DIGIT_W-1:0] tens_seg,
  output logic [DIGIT_W-1:0] ones_seg
);

  if (MAX_COUNT < 1 || MAX_COUNT > 99) begin : g_bad_max
    $error("timer: MAX_COUNT out of range 1..99");
  end

  localparam bcd_t MAX_TENS = tens_of(MAX_COUNT);
  localparam bcd_t MAX_ONES = ones_of(MAX_COUNT);

  bcd_t ones;
  bcd_t tens;
  logic ones_carry;
  logic tens_at_max;
  logic tens_inc;
  logic wrap;

  assign tens_inc = en & ones_carry;

  // tens terminal is MAX_TENS, so its carry flags the top tens value
  assign wrap = en & tens_at_max & (ones == MAX_ONES);

  bcd_digit u_ones (
    .clk   (clk_1hz),
    .rst_n (rst_n),
    .inc   (en),
    .clr   (wrap),
    .term  (DIGIT_MAX),
    .digit (ones),
    .carry (ones_carry)
  );

  bcd_digit u_tens (
    .clk   (clk_1hz),
    .rst_n (rst_n),
    .inc   (tens_inc),
    .clr   (wrap),
    .term  (MAX_TENS),
    .digit (tens),
    .carry (tens_at_max)
  );

  assign tens_seg = tens;
  assign ones_seg = ones;

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for timer: driver pushes model counts, monitor compares.
// Two instances run in lockstep with MAX_COUNT 59 and 23.
module tb_timer;

  logic       clk_1hz = 1'b0;
  logic       rst_n   = 1'b1;
  logic       en      = 1'b0;
  logic [3:0] t59;
  logic [3:0] o59;
  logic [3:0] t23;
  logic [3:0] o23;

  timer #(.MAX_COUNT(59)) dut (
    .clk_1hz  (clk_1hz),
    .rst_n    (rst_n),
    .en       (en),
    .tens_seg (t59),
    .ones_seg (o59)
  );

  timer #(.MAX_COUNT(23)) dut23 (
    .clk_1hz  (clk_1hz),
    .rst_n    (rst_n),
    .en       (en),
    .tens_seg (t23),
    .ones_seg (o23)
  );

  always #10 clk_1hz = ~clk_1hz;

  int    checks   = 0;
  int    failures = 0;
  int    exp_q[$];
  int    m59 = 0;
  int    m23 = 0;
  int    x;
  int    e59;
  int    e23;
  string scen = "init";

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s/%s actual=%0d required=%0d", scen, name, act, exp);
    end
  endtask

  // Decimal model: count in plain integers, wrap at the maximum.
  task automatic step(input bit e, input bit r);
    @(negedge clk_1hz);
    if (rst_n && !r) begin
      exp_q.push_back(0);
    end
    rst_n = r;
    en    = e;
    if (!r) begin
      m59 = 0;
      m23 = 0;
    end else if (e) begin
      m59 = (m59 == 59) ? 0 : m59 + 1;
      m23 = (m23 == 23) ? 0 : m23 + 1;
    end
    exp_q.push_back(m59 * 100 + m23);
    #4 en = ~e;
    #2 en = e;
  endtask

  initial begin
    forever begin
      @(posedge clk_1hz or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        e59 = x / 100;
        e23 = x % 100;
        check("tens59", int'(t59), e59 / 10);
        check("ones59", int'(o59), e59 % 10);
        check("tens23", int'(t23), e23 / 10);
        check("ones23", int'(o23), e23 % 10);
        check("inv59", int'(t59 <= 9 && o59 <= 9 &&
              (int'(t59) * 10 + int'(o59)) <= 59), 1);
        check("inv23", int'(t23 <= 9 && o23 <= 9 &&
              (int'(t23) * 10 + int'(o23)) <= 23), 1);
      end
    end
  end

  initial begin
    scen = "reset";
    repeat (2) step(1'b1, 1'b0);

    scen = "count";
    repeat (10) step(1'b1, 1'b1);

    scen = "hold";
    step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b1);

    scen = "wrap";
    step(1'b1, 1'b0);
    repeat (61) step(1'b1, 1'b1);

    scen = "midreset";
    step(1'b1, 1'b0);
    repeat (37) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    scen = "random";
    repeat (400) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) != 0);
    end

    scen = "drain";
    repeat (3) @(negedge clk_1hz);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 The block SHALL have one parameter: MAX_COUNT, default 59, meaning the highest count value in decimal before wrap-around; legal range is 1..99.
REQ-002 The block SHALL have a port clk_1hz, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have a port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have a port en, input, 1 bit: count enable, active-high, sampled on the rising edge of clk_1hz.
REQ-005 The block SHALL have a port tens_seg, output, 4 bits: the BCD tens digit of the current count (0..9), intended for a BCD-to-7-segment decoder.
REQ-006 The block SHALL have a port ones_seg, output, 4 bits: the BCD ones digit of the current count (0..9), intended for a BCD-to-7-segment decoder.

Function
REQ-007 The block SHALL hold the count as two registered BCD digits; tens_seg and ones_seg SHALL be driven directly from these registers, with no combinational path from en.
REQ-008 On each rising clk_1hz edge with rst_n=1 and en=1, the count SHALL increment by one decimal unit.
REQ-009 On each rising clk_1hz edge with en=0, both digits SHALL hold their values.
REQ-010 When the ones digit is 9 and an increment occurs, the ones digit SHALL become 0 and the tens digit SHALL increment in the same edge.
REQ-011 When the count equals MAX_COUNT (tens=MAX_COUNT/10, ones=MAX_COUNT%10) and an increment occurs, both digits SHALL become 0 in the same edge (default sequence 58 -> 59 -> 00).
REQ-012 Each output digit SHALL never hold a non-BCD code (10..15) after reset.
REQ-013 Latency from an enabled edge to the updated output SHALL be zero cycles beyond that edge: the new value is visible immediately after the edge.
REQ-014 en toggling between edges SHALL have no effect; only its value at the rising edge matters.

Reset
REQ-015 While rst_n=0, tens_seg and ones_seg SHALL be 0 regardless of clk_1hz and en.
REQ-016 Assertion of rst_n SHALL clear the count immediately, without waiting for a clock edge, including mid-count.
REQ-017 Reset SHALL take priority over en; the first enabled rising edge after rst_n returns to 1 SHALL produce count 01.
REQ-018 Before the first reset, the output values are undefined; a reset SHALL be applied before the outputs are used.

Structure
REQ-019 A shared package SHALL hold the BCD digit width (4) and the digit maximum (9) constants.
REQ-020 One sub-module, bcd_digit, SHALL implement a single BCD digit with inputs for clock, reset, increment-enable, clear and terminal value, and outputs for the digit and a carry/terminal flag; timer SHALL instantiate it twice, chained through the carry.
REQ-021 The wrap compare against MAX_COUNT SHALL be performed in timer and fed to both digit clear inputs.

Verification
REQ-022 Reset scenario: rst_n=0 for 2 cycles with en=1 -> outputs are 0/0 throughout, and the clear is visible before the next clock edge.
REQ-023 Counting scenario: release reset with en=1, apply 10 edges (20 ns period) -> count runs 01..09 then 10 (tens=1, ones=0).
REQ-024 Hold scenario: count reaches 10, then en=0 for 1 edge -> the count stays at 10; en=1 for 4 edges -> the count becomes 14.
REQ-025 Wrap scenario: 59 enabled edges after reset reach 59; the next edge gives 00 and the edge after gives 01.
REQ-026 Mid-count reset scenario: at count 37, pull rst_n low between edges -> outputs go to 00 asynchronously; after release plus 1 enabled edge -> 01.
REQ-027 Invariant scenario: across all scenarios, assert that each digit is <= 9 and that the decimal value is <= MAX_COUNT; repeat the wrap scenario with MAX_COUNT=23 (23 -> 00).
